out_channel_streamer: RTL and testbench

Buffers the words a generated-program engine writes to its out channel and streams them to a host-side consumer over a valid/ready handshake. Sits directly downstream of the `fpga` program engine: each engine `out` instruction becomes one write strobe here. On the engine's `finished`, the block drains the remaining words, flags the final one and reports completion, word count and an optional checksum.

---
 rtl/out_channel_streamer.sv | 113 +++++++++++
 tb/tb_out_channel_streamer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_channel_streamer.sv
// Out-channel FIFO between the program engine and a valid/ready host consumer.
// Optional checksum accumulation enabled by OUT_CHANNEL_CHECKSUM_EN.
module out_channel_streamer #(
  parameter int MemoryElementWidth = 12,
  parameter int Depth = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [MemoryElementWidth-1:0] wr_data,
  output logic                          wr_full,
  input  logic                          finished,
  output logic                          m_valid,
  output logic [MemoryElementWidth-1:0] m_data,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic                          done,
  output logic                          overflow,
  output logic [15:0]                   count,
  output logic [MemoryElementWidth-1:0] checksum
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL = (AW+1)'(Depth);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [MemoryElementWidth-1:0] mem [Depth];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] occ, occ_nxt;
  logic wr_en, pop, drop;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Drain completion looks at occupancy after this cycle's pop.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (finished) state_nxt = DRAIN;
      DRAIN:   if (occ_nxt == '0) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  always_comb begin
    wr_full = (occ == FULL);
    m_valid = (occ != '0) && (state != DONE);
    m_last  = m_valid && (state == DRAIN) && (occ == ONE);
    done    = (state == DONE);
    wr_en   = (state == RUN) && wr_valid && !wr_full;
    drop    = (state == RUN) && wr_valid && wr_full;
    pop     = m_valid && m_ready;
  end

  always_comb begin
    occ_nxt = occ;
    unique case ({wr_en, pop})
      2'b10:   occ_nxt = occ + ONE;
      2'b01:   occ_nxt = occ - ONE;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      occ <= occ_nxt;
      if (wr_en) wr_ptr <= wr_ptr + PONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PONE;
        count  <= count + 16'd1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is not cleared; reset only discards it via the pointers.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign m_data = mem[rd_ptr];

`ifdef OUT_CHANNEL_CHECKSUM_EN
  logic [MemoryElementWidth-1:0] sum_q;

  always_ff @(posedge clock) begin
    if (reset)    sum_q <= '0;
    else if (pop) sum_q <= sum_q + m_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_out_channel_streamer.sv
// Directed scoreboard bench for out_channel_streamer.
// Words are queued when written and checked in order at each handshake.
module tb_out_channel_streamer;

  logic        clock;
  logic        reset;
  logic        wr_valid;
  logic [11:0] wr_data;
  logic        wr_full;
  logic        finished;
  logic        m_valid;
  logic [11:0] m_data;
  logic        m_ready;
  logic        m_last;
  logic        done;
  logic        overflow;
  logic [15:0] count;
  logic [11:0] checksum;

  out_channel_streamer #(
    .MemoryElementWidth(12),
    .Depth(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_full(wr_full),
    .finished(finished),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .m_last(m_last),
    .done(done),
    .overflow(overflow),
    .count(count),
    .checksum(checksum)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] q[$];
  int exp_count = 0;
  logic [11:0] exp_sum = '0;
  logic drain_flag = 1'b0;
  int last_seen = 0;
  logic [11:0] hold;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_ck();
`ifdef OUT_CHANNEL_CHECKSUM_EN
    return exp_sum;
`else
    return 12'd0;
`endif
  endfunction

  // Inputs are stable from posedge+1 to the next posedge, so a
  // handshake seen here is the one the next edge completes.
  always @(negedge clock) begin
    if (!reset) begin
      chk("m_last", m_last,
          m_valid && drain_flag && q.size() == 1);
      if (m_last) last_seen++;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 1'b1, 1'b0);
        end else begin
          chk("m_data_order", m_data, q.pop_front());
          exp_count++;
          exp_sum = exp_sum + m_data;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    finished = 1'b0;
    m_ready = 1'b0;
    wr_valid = 1'b0;
    cyc();
    reset = 1'b0;
    q.delete();
    exp_count = 0;
    exp_sum = '0;
    drain_flag = 1'b0;
    last_seen = 0;
  endtask

  task automatic wr(input logic [11:0] d, input logic accepted);
    wr_valid = 1'b1;
    wr_data = d;
    if (accepted) q.push_back(d);
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      if (q.size() == 0) break;
      cyc();
    end
    chk({tag, "_drain_timeout"}, q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    finished = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wr_full", wr_full, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", count, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b0;

    // single word, no bypass
    m_ready = 1'b1;
    chk("t1_pre_valid", m_valid, 0);
    wr(12'd2, 1'b1);
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_data", m_data, 2);
    cyc();
    chk("t1_count", count, 1);
    chk("t1_checksum", checksum, exp_ck());

    // streaming with simultaneous write/pop, pointer wrap
    for (int i = 20; i < 32; i++) wr(12'(i), 1'b1);
    drain_all("t1b");
    cyc();
    chk("t1b_count", count, 16'(exp_count));
    chk("t1b_checksum", checksum, exp_ck());
    chk("t1b_overflow", overflow, 0);

    // fill, overflow, full with concurrent pop
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      chk("t2_not_full", wr_full, 0);
      wr(12'(i), 1'b1);
    end
    chk("t2_full", wr_full, 1);
    wr(12'd9, 1'b0);
    chk("t2_overflow", overflow, 1);
    m_ready = 1'b1;
    wr(12'd50, 1'b0);
    chk("t2_after_pop_full", wr_full, 0);
    drain_all("t2");
    cyc();
    chk("t2_count", count, 8);
    chk("t2_count_model", count, 16'(exp_count));
    chk("t2_m_valid", m_valid, 0);

    // finish with words pending
    do_reset();
    wr(12'd5, 1'b1);
    wr(12'd6, 1'b1);
    wr(12'd7, 1'b1);
    finished = 1'b1;
    m_ready = 1'b1;
    cyc();
    drain_flag = 1'b1;
    chk("t3_not_done", done, 0);
    drain_all("t3");
    chk("t3_done", done, 1);
    chk("t3_m_valid", m_valid, 0);
    chk("t3_count", count, 3);
    chk("t3_checksum", checksum, exp_ck());
    chk("t3_sum_model", exp_sum, 18);
    chk("t3_last_once", last_seen, 1);
    cyc();
    chk("t3_done_sticky", done, 1);

    // zero-word program
    do_reset();
    finished = 1'b1;
    cyc();
    drain_flag = 1'b1;
    chk("t4_done_n1", done, 0);
    cyc();
    chk("t4_done_n2", done, 1);
    chk("t4_count", count, 0);
    chk("t4_last_never", last_seen, 0);
    wr(12'd77, 1'b0);
    chk("t4_done_write_ignored", m_valid, 0);
    chk("t4_overflow", overflow, 0);

    // stalls and writes during drain
    do_reset();
    for (int i = 10; i < 14; i++) wr(12'(i), 1'b1);
    finished = 1'b1;
    cyc();
    drain_flag = 1'b1;
    wr_valid = 1'b1;
    wr_data = 12'd99;
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    hold = m_data;
    chk("t5_hold_val", hold, 11);
    cyc();
    chk("t5_stall1", m_data, 16'(hold));
    cyc();
    chk("t5_stall2", m_data, 16'(hold));
    m_ready = 1'b1;
    drain_all("t5");
    wr_valid = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_count", count, 4);
    chk("t5_overflow", overflow, 0);
    chk("t5_checksum", checksum, exp_ck());

    // reset mid-drain
    do_reset();
    for (int i = 1; i <= 4; i++) wr(12'(i), 1'b1);
    m_ready = 1'b1;
    finished = 1'b1;
    cyc();
    drain_flag = 1'b1;
    m_ready = 1'b0;
    chk("t6_pre_count", count, 1);
    chk("t6_pre_valid", m_valid, 1);
    reset = 1'b1;
    finished = 1'b0;
    cyc();
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_last", m_last, 0);
    chk("t6_done", done, 0);
    chk("t6_count", count, 0);
    chk("t6_wr_full", wr_full, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_checksum", checksum, 0);
    reset = 1'b0;
    q.delete();
    drain_flag = 1'b0;
    cyc();
    chk("t6_still_empty", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
